// File: rtl/mdio_pkg.sv
// Shared types and constants for the MDIO management responder.
package mdio_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ST,
        OP,
        PHYAD,
        REGAD,
        TA,
        DATA
    } mdio_state_t;

    localparam logic [1:0] OP_READ  = 2'b10;
    localparam logic [1:0] OP_WRITE = 2'b01;

    localparam int PREAMBLE_LEN = 32;
    localparam int OP_LEN       = 2;
    localparam int PHYAD_LEN    = 5;
    localparam int REGAD_LEN    = 5;
    localparam int TA_LEN       = 2;
    localparam int DATA_LEN     = 16;

    localparam logic [4:0]  REG_CTRL     = 5'd0;
    localparam logic [4:0]  REG_STATUS   = 5'd1;
    localparam logic [4:0]  REG_ID1      = 5'd2;
    localparam logic [4:0]  REG_ID2      = 5'd3;
    localparam logic [4:0]  REG_SCRATCH0 = 5'd4;
    localparam logic [4:0]  REG_SCRATCH3 = 5'd7;
    localparam logic [15:0] CTRL_RESET   = 16'h1140;

    // Number of mdc edges spent in each frame field.
    function automatic logic [4:0] field_len(input mdio_state_t s);
        case (s)
            OP:      return 5'(OP_LEN);
            PHYAD:   return 5'(PHYAD_LEN);
            REGAD:   return 5'(REGAD_LEN);
            TA:      return 5'(TA_LEN);
            DATA:    return 5'(DATA_LEN);
            default: return 5'd1;
        endcase
    endfunction

    // Registers that accept writes: control and the scratch bank.
    function automatic logic is_writable(input logic [4:0] a);
        return (a == REG_CTRL) || (a >= REG_SCRATCH0 && a <= REG_SCRATCH3);
    endfunction

    function automatic logic [15:0] bit_reverse16(input logic [15:0] v);
        logic [15:0] r;
        for (int i = 0; i < 16; i++) r[i] = v[15-i];
        return r;
    endfunction

endpackage

// File: rtl/mdio_sync.sv
// Brings mdc and mdio_in into the clk domain and flags mdc rising edges.
module mdio_sync (
    input  logic clk,
    input  logic rst,
    input  logic mdc,
    input  logic mdio_in,
    output logic mdc_rise,
    output logic mdio_s
);

    logic mdc_meta_reg, mdc_sync_reg, mdc_prev_reg;
    logic mdio_meta_reg, mdio_sync_reg;

    // Two-stage synchronizers plus one delay stage for edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            mdc_meta_reg  <= 1'b0;
            mdc_sync_reg  <= 1'b0;
            mdc_prev_reg  <= 1'b0;
            mdio_meta_reg <= 1'b0;
            mdio_sync_reg <= 1'b0;
        end else begin
            mdc_meta_reg  <= mdc;
            mdc_sync_reg  <= mdc_meta_reg;
            mdc_prev_reg  <= mdc_sync_reg;
            mdio_meta_reg <= mdio_in;
            mdio_sync_reg <= mdio_meta_reg;
        end
    end

    assign mdc_rise = mdc_sync_reg & ~mdc_prev_reg;
    assign mdio_s   = mdio_sync_reg;

endmodule

// File: rtl/mdio_responder.sv
// Clause-22 style MDIO slave with a small register map.
module mdio_responder
    import mdio_pkg::*;
#(
    parameter logic [4:0]  PHY_ADDR       = 5'd1,
    parameter logic [31:0] PHY_ID         = 32'h0022_1620,
    parameter bit          DATA_LSB_FIRST = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mdc,
    input  logic        mdio_in,
    output logic        mdio_out,
    output logic        mdio_oe,
    input  logic [15:0] status_in,
    output logic [15:0] ctrl_out,
    output logic        wr_strobe,
    output logic [4:0]  wr_addr,
    output logic [15:0] wr_data,
    output logic        busy,
    output logic        frame_err
);

    logic        mdc_rise, mdio_s;
    mdio_state_t state_reg, state_next;
    logic [4:0]  cnt_reg, cnt_next;
    logic [5:0]  pre_cnt_reg, pre_cnt_next;
    logic        frame_err_reg, frame_err_next;
    logic [1:0]  op_reg, op_next;
    logic [4:0]  phyad_reg, phyad_next, regad_reg, regad_next;
    logic [15:0] shift_reg, shift_next;
    logic        oe_reg, oe_next, out_reg, out_next;
    logic        wr_strobe_reg;
    logic [4:0]  wr_addr_reg;
    logic [15:0] wr_data_reg, ctrl_reg;
    logic [15:0] scratch_q [4];
    logic        wr_en;
    logic [15:0] wr_value, read_data;
    logic [4:0]  regad_full;
    logic        field_last, phy_match;

    mdio_sync u_sync (
        .clk      (clk),
        .rst      (rst),
        .mdc      (mdc),
        .mdio_in  (mdio_in),
        .mdc_rise (mdc_rise),
        .mdio_s   (mdio_s)
    );

    assign field_last = (cnt_reg == field_len(state_reg) - 5'd1);
    assign phy_match  = (phyad_reg == PHY_ADDR);
    assign regad_full = {regad_reg[3:0], mdio_s};

    // State, field counter and preamble counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            pre_cnt_reg   <= '0;
            frame_err_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            pre_cnt_reg   <= pre_cnt_next;
            frame_err_reg <= frame_err_next;
        end
    end

    // Frame sequencing: preamble hunt, start/opcode validation, field walk.
    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        pre_cnt_next   = pre_cnt_reg;
        frame_err_next = 1'b0;
        if (mdc_rise) begin
            cnt_next = field_last ? 5'd0 : cnt_reg + 5'd1;
            unique case (state_reg)
                IDLE: begin
                    if (mdio_s) begin
                        if (pre_cnt_reg != 6'(PREAMBLE_LEN)) pre_cnt_next = pre_cnt_reg + 6'd1;
                    end else begin
                        pre_cnt_next = '0;
                        if (pre_cnt_reg == 6'(PREAMBLE_LEN)) state_next = ST;
                    end
                end
                ST: begin
                    if (mdio_s) begin
                        state_next = OP;
                    end else begin
                        frame_err_next = 1'b1;
                        state_next     = IDLE;
                    end
                end
                OP: begin
                    if (field_last) begin
                        if ({op_reg[0], mdio_s} == OP_READ || {op_reg[0], mdio_s} == OP_WRITE) begin
                            state_next = PHYAD;
                        end else begin
                            frame_err_next = 1'b1;
                            state_next     = IDLE;
                        end
                    end
                end
                PHYAD: if (field_last) state_next = REGAD;
                REGAD: if (field_last) state_next = TA;
                TA:    if (field_last) state_next = DATA;
                DATA:  if (field_last) state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    // Read data selected by the register address completed at E0.
    always_comb begin
        read_data = 16'h0000;
        if (regad_full == REG_CTRL)                 read_data = ctrl_reg;
        else if (regad_full == REG_STATUS)          read_data = status_in;
        else if (regad_full == REG_ID1)             read_data = PHY_ID[31:16];
        else if (regad_full == REG_ID2)             read_data = PHY_ID[15:0];
        else if (regad_full[4:2] == 3'b001)         read_data = scratch_q[regad_full[1:0]];
    end

    // Field capture, read serialisation and write commit decision.
    always_comb begin
        op_next    = op_reg;
        phyad_next = phyad_reg;
        regad_next = regad_reg;
        shift_next = shift_reg;
        oe_next    = oe_reg;
        out_next   = out_reg;
        wr_en      = 1'b0;
        wr_value   = DATA_LSB_FIRST ? bit_reverse16({shift_reg[14:0], mdio_s})
                                    : {shift_reg[14:0], mdio_s};
        if (mdc_rise) begin
            case (state_reg)
                OP:    op_next    = {op_reg[0], mdio_s};
                PHYAD: phyad_next = {phyad_reg[3:0], mdio_s};
                REGAD: begin
                    regad_next = regad_full;
                    if (field_last) shift_next = DATA_LSB_FIRST ? bit_reverse16(read_data) : read_data;
                end
                TA: begin
                    if (op_reg == OP_READ && phy_match) begin
                        if (cnt_reg == 5'd0) begin
                            oe_next  = 1'b1;
                            out_next = 1'b0;
                        end else begin
                            out_next   = shift_reg[15];
                            shift_next = {shift_reg[14:0], 1'b0};
                        end
                    end
                end
                DATA: begin
                    if (field_last) begin
                        oe_next  = 1'b0;
                        out_next = 1'b0;
                    end
                    if (op_reg == OP_READ) begin
                        if (!field_last && phy_match) begin
                            out_next   = shift_reg[15];
                            shift_next = {shift_reg[14:0], 1'b0};
                        end
                    end else begin
                        shift_next = {shift_reg[14:0], mdio_s};
                        if (field_last && phy_match && is_writable(regad_reg)) wr_en = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Datapath registers, control register and write reporting.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_reg        <= '0;
            phyad_reg     <= '0;
            regad_reg     <= '0;
            shift_reg     <= '0;
            oe_reg        <= 1'b0;
            out_reg       <= 1'b0;
            wr_strobe_reg <= 1'b0;
            wr_addr_reg   <= '0;
            wr_data_reg   <= '0;
            ctrl_reg      <= CTRL_RESET;
        end else begin
            op_reg        <= op_next;
            phyad_reg     <= phyad_next;
            regad_reg     <= regad_next;
            shift_reg     <= shift_next;
            oe_reg        <= oe_next;
            out_reg       <= out_next;
            wr_strobe_reg <= wr_en;
            if (wr_en) begin
                wr_addr_reg <= regad_reg;
                wr_data_reg <= wr_value;
                if (regad_reg == REG_CTRL) ctrl_reg <= wr_value;
            end
        end
    end

    for (genvar gi = 0; gi < 4; gi++) begin : g_scratch
        logic [15:0] q_reg;
        // One scratch register, written only when its address commits.
        always_ff @(posedge clk) begin
            if (rst) q_reg <= '0;
            else if (wr_en && regad_reg == REG_SCRATCH0 + 5'(gi)) q_reg <= wr_value;
        end
        assign scratch_q[gi] = q_reg;
    end

    assign mdio_out  = out_reg;
    assign mdio_oe   = oe_reg;
    assign ctrl_out  = ctrl_reg;
    assign wr_strobe = wr_strobe_reg;
    assign wr_addr   = wr_addr_reg;
    assign wr_data   = wr_data_reg;
    assign frame_err = frame_err_reg;
    assign busy      = (state_reg != IDLE) && (state_reg != ST);

endmodule

// File: tb/tb_mdio_responder.sv
// Station-side bench for mdio_responder: directed table, random frames, corner sequences.
module tb_mdio_responder;

    localparam logic [1:0] OPR = 2'b10;
    localparam logic [1:0] OPW = 2'b01;

    logic        clk = 1'b0;
    logic        rst, mdc, mdio_in, mdio_out, mdio_oe;
    logic [15:0] status_in, ctrl_out, wr_data;
    logic        wr_strobe, busy, frame_err;
    logic [4:0]  wr_addr;

    always #5 clk = ~clk;

    mdio_responder dut (
        .clk       (clk),
        .rst       (rst),
        .mdc       (mdc),
        .mdio_in   (mdio_in),
        .mdio_out  (mdio_out),
        .mdio_oe   (mdio_oe),
        .status_in (status_in),
        .ctrl_out  (ctrl_out),
        .wr_strobe (wr_strobe),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .busy      (busy),
        .frame_err (frame_err)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Pulse/drive monitors, sampled away from the active edge.
    int strobe_cnt = 0, ferr_cnt = 0, oe_cnt = 0;
    always @(negedge clk) begin
        if (wr_strobe) strobe_cnt++;
        if (frame_err) ferr_cnt++;
        if (mdio_oe)   oe_cnt++;
    end

    // Reference register model.
    logic [31:0] phy_id_v = 32'h0022_1620;
    logic [15:0] m_ctrl;
    logic [15:0] m_scr [4];
    logic [4:0]  m_wa;
    logic [15:0] m_wd;

    task automatic model_reset();
        m_ctrl = 16'h1140;
        for (int i = 0; i < 4; i++) m_scr[i] = 16'h0000;
        m_wa = 5'd0;
        m_wd = 16'h0000;
    endtask

    function automatic logic model_wr_ok(input logic [1:0] op, input logic [4:0] phy, input logic [4:0] ra);
        return op == OPW && phy == 5'd1 && (ra == 5'd0 || (ra >= 5'd4 && ra <= 5'd7));
    endfunction

    function automatic logic [15:0] model_read(input logic [4:0] ra, input logic [15:0] st);
        if (ra == 5'd0) return m_ctrl;
        if (ra == 5'd1) return st;
        if (ra == 5'd2) return phy_id_v[31:16];
        if (ra == 5'd3) return phy_id_v[15:0];
        if (ra >= 5'd4 && ra <= 5'd7) return m_scr[ra[1:0]];
        return 16'h0000;
    endfunction

    task automatic model_apply(input logic [1:0] op, input logic [4:0] phy, input logic [4:0] ra, input logic [15:0] wd);
        if (model_wr_ok(op, phy, ra)) begin
            if (ra == 5'd0) m_ctrl = wd;
            else m_scr[ra[1:0]] = wd;
            m_wa = ra;
            m_wd = wd;
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One mdc period; returns the line level seen just before the rising edge.
    task automatic mdc_bit(input logic b, output logic line);
        mdio_in = b;
        repeat (4) @(negedge clk);
        line = mdio_oe ? mdio_out : 1'b1;
        mdc = 1'b1;
        repeat (4) @(negedge clk);
        mdc = 1'b0;
    endtask

    task automatic send_header(input int npre, input logic [1:0] op, input logic [4:0] phy, input logic [4:0] ra);
        logic l;
        for (int i = 0; i < npre; i++) mdc_bit(1'b1, l);
        mdc_bit(1'b0, l);
        mdc_bit(1'b1, l);
        for (int i = 1; i >= 0; i--) mdc_bit(op[i], l);
        for (int i = 4; i >= 0; i--) mdc_bit(phy[i], l);
        for (int i = 4; i >= 0; i--) mdc_bit(ra[i], l);
    endtask

    task automatic do_frame(input int npre, input logic [1:0] op, input logic [4:0] phy, input logic [4:0] ra,
                            input logic [15:0] wd, output logic [15:0] rd, output logic ta2);
        logic l;
        send_header(npre, op, phy, ra);
        mdc_bit(1'b1, l);
        mdc_bit(op == OPW ? 1'b0 : 1'b1, ta2);
        for (int i = 15; i >= 0; i--) begin
            mdc_bit(op == OPW ? wd[i] : 1'b1, l);
            rd[i] = l;
        end
        mdc_bit(1'b1, l);
    endtask

    typedef struct {
        logic [1:0]  op;
        logic [4:0]  phy;
        logic [4:0]  ra;
        logic [15:0] wd;
        logic [15:0] st;
        logic [15:0] exp_rd;
        logic        exp_wr;
        logic [15:0] exp_ctrl;
    } vec_t;

    vec_t vecs [14];

    initial begin
        logic [15:0] rd, exp;
        logic        ta2, l, ewr;
        int          s0, f0, o0;
        logic [1:0]  op;
        logic [4:0]  phy, ra;
        logic [15:0] wd, st;
        logic [7:0]  partial;

        vecs[0]  = '{OPR, 5'd1, 5'd2, 16'h0000, 16'h0000, 16'h0022, 1'b0, 16'h1140};
        vecs[1]  = '{OPR, 5'd1, 5'd3, 16'h0000, 16'h0000, 16'h1620, 1'b0, 16'h1140};
        vecs[2]  = '{OPR, 5'd1, 5'd0, 16'h0000, 16'h0000, 16'h1140, 1'b0, 16'h1140};
        vecs[3]  = '{OPW, 5'd1, 5'd4, 16'hA5C3, 16'h0000, 16'h0000, 1'b1, 16'h1140};
        vecs[4]  = '{OPR, 5'd1, 5'd4, 16'h0000, 16'h0000, 16'hA5C3, 1'b0, 16'h1140};
        vecs[5]  = '{OPW, 5'd1, 5'd2, 16'h1234, 16'h0000, 16'h0000, 1'b0, 16'h1140};
        vecs[6]  = '{OPR, 5'd1, 5'd2, 16'h0000, 16'h0000, 16'h0022, 1'b0, 16'h1140};
        vecs[7]  = '{OPW, 5'd1, 5'd9, 16'hBEEF, 16'h0000, 16'h0000, 1'b0, 16'h1140};
        vecs[8]  = '{OPR, 5'd1, 5'd9, 16'h0000, 16'h0000, 16'h0000, 1'b0, 16'h1140};
        vecs[9]  = '{OPW, 5'd3, 5'd0, 16'hFFFF, 16'h0000, 16'h0000, 1'b0, 16'h1140};
        vecs[10] = '{OPR, 5'd1, 5'd0, 16'h0000, 16'h0000, 16'h1140, 1'b0, 16'h1140};
        vecs[11] = '{OPW, 5'd1, 5'd0, 16'h1234, 16'h0000, 16'h0000, 1'b1, 16'h1234};
        vecs[12] = '{OPR, 5'd1, 5'd1, 16'h0000, 16'h55AA, 16'h55AA, 1'b0, 16'h1234};
        vecs[13] = '{OPR, 5'd3, 5'd2, 16'h0000, 16'h0000, 16'h0000, 1'b0, 16'h1234};

        rst = 1'b1; mdc = 1'b0; mdio_in = 1'b1; status_in = 16'h0000;
        model_reset();
        repeat (4) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset mdio_oe", 32'(mdio_oe), 32'd0);
        check("reset mdio_out", 32'(mdio_out), 32'd0);
        check("reset wr_strobe", 32'(wr_strobe), 32'd0);
        check("reset frame_err", 32'(frame_err), 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        check("reset wr_addr", 32'(wr_addr), 32'd0);
        check("reset wr_data", 32'(wr_data), 32'd0);
        check("reset ctrl_out", 32'(ctrl_out), 32'h1140);

        // Directed table.
        for (int i = 0; i < 14; i++) begin
            status_in = vecs[i].st;
            s0 = strobe_cnt; f0 = ferr_cnt; o0 = oe_cnt;
            do_frame(32, vecs[i].op, vecs[i].phy, vecs[i].ra, vecs[i].wd, rd, ta2);
            $display("vec %0d op=%b phy=%0d reg=%0d wd=%h rd=%h strobes=%0d ctrl=%h",
                     i, vecs[i].op, vecs[i].phy, vecs[i].ra, vecs[i].wd, rd, strobe_cnt - s0, ctrl_out);
            if (vecs[i].op == OPR && vecs[i].phy == 5'd1) begin
                check($sformatf("vec%0d read data", i), 32'(rd), 32'(vecs[i].exp_rd));
                check($sformatf("vec%0d TA slot2", i), 32'(ta2), 32'd0);
            end
            if (vecs[i].phy != 5'd1)
                check($sformatf("vec%0d no drive", i), 32'(oe_cnt - o0), 32'd0);
            check($sformatf("vec%0d strobes", i), 32'(strobe_cnt - s0), 32'(vecs[i].exp_wr));
            if (vecs[i].exp_wr) begin
                check($sformatf("vec%0d wr_addr", i), 32'(wr_addr), 32'(vecs[i].ra));
                check($sformatf("vec%0d wr_data", i), 32'(wr_data), 32'(vecs[i].wd));
            end
            check($sformatf("vec%0d ctrl_out", i), 32'(ctrl_out), 32'(vecs[i].exp_ctrl));
            check($sformatf("vec%0d oe released", i), 32'(mdio_oe), 32'd0);
            check($sformatf("vec%0d busy low", i), 32'(busy), 32'd0);
            check($sformatf("vec%0d no frame_err", i), 32'(ferr_cnt - f0), 32'd0);
            model_apply(vecs[i].op, vecs[i].phy, vecs[i].ra, vecs[i].wd);
        end

        // Randomized frames against the register model.
        for (int i = 0; i < 24; i++) begin
            op  = ($urandom_range(0, 1) == 0) ? OPR : OPW;
            phy = ($urandom_range(0, 5) == 0) ? 5'd3 : 5'd1;
            ra  = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
            wd  = 16'($urandom);
            st  = 16'($urandom);
            status_in = st;
            exp = model_read(ra, st);
            ewr = model_wr_ok(op, phy, ra);
            s0 = strobe_cnt; o0 = oe_cnt;
            do_frame(32, op, phy, ra, wd, rd, ta2);
            model_apply(op, phy, ra, wd);
            $display("rnd %0d op=%b phy=%0d reg=%0d wd=%h rd=%h strobes=%0d", i, op, phy, ra, wd, rd, strobe_cnt - s0);
            if (op == OPR && phy == 5'd1) check($sformatf("rnd%0d read data", i), 32'(rd), 32'(exp));
            if (phy != 5'd1) check($sformatf("rnd%0d no drive", i), 32'(oe_cnt - o0), 32'd0);
            check($sformatf("rnd%0d strobes", i), 32'(strobe_cnt - s0), 32'(ewr));
            check($sformatf("rnd%0d wr_addr", i), 32'(wr_addr), 32'(m_wa));
            check($sformatf("rnd%0d wr_data", i), 32'(wr_data), 32'(m_wd));
            check($sformatf("rnd%0d ctrl_out", i), 32'(ctrl_out), 32'(m_ctrl));
        end

        // Short preamble: 31 ones must not open a frame.
        mdc_bit(1'b0, l);
        s0 = strobe_cnt; f0 = ferr_cnt; o0 = oe_cnt;
        do_frame(31, OPR, 5'd1, 5'd2, 16'h0000, rd, ta2);
        $display("short preamble read rd=%h oe_cycles=%0d", rd, oe_cnt - o0);
        check("short preamble no drive", 32'(oe_cnt - o0), 32'd0);
        check("short preamble no frame_err", 32'(ferr_cnt - f0), 32'd0);

        // Bad start bits, then recovery.
        f0 = ferr_cnt;
        for (int i = 0; i < 32; i++) mdc_bit(1'b1, l);
        mdc_bit(1'b0, l);
        mdc_bit(1'b0, l);
        $display("bad start frame_err pulses=%0d busy=%b", ferr_cnt - f0, busy);
        check("bad start frame_err once", 32'(ferr_cnt - f0), 32'd1);
        check("bad start busy low", 32'(busy), 32'd0);
        do_frame(32, OPR, 5'd1, 5'd3, 16'h0000, rd, ta2);
        $display("after bad start read rd=%h", rd);
        check("after bad start read", 32'(rd), 32'h1620);
        check("after bad start frame_err", 32'(ferr_cnt - f0), 32'd1);

        // Reset in the middle of a status read.
        status_in = 16'h796D;
        send_header(32, OPR, 5'd1, 5'd1);
        mdc_bit(1'b1, l);
        mdc_bit(1'b1, l);
        for (int i = 7; i >= 0; i--) begin
            mdc_bit(1'b1, l);
            partial[i] = l;
        end
        check("mid read upper byte", 32'(partial), 32'h79);
        check("mid read driving", 32'(mdio_oe), 32'd1);
        check("mid read busy", 32'(busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        $display("reset mid read oe=%b busy=%b", mdio_oe, busy);
        check("reset releases oe", 32'(mdio_oe), 32'd0);
        check("reset clears busy", 32'(busy), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        check("post reset ctrl_out", 32'(ctrl_out), 32'(m_ctrl));
        check("post reset wr_addr", 32'(wr_addr), 32'(m_wa));
        do_frame(32, OPR, 5'd1, 5'd1, 16'h0000, rd, ta2);
        $display("post reset status read rd=%h", rd);
        check("post reset status read", 32'(rd), 32'h796D);
        do_frame(32, OPR, 5'd1, 5'd5, 16'h0000, rd, ta2);
        $display("post reset scratch read rd=%h", rd);
        check("post reset scratch read", 32'(rd), 32'(model_read(5'd5, status_in)));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
